fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares the write side of the async FIFO among `N` requesters in the write clock domain. Each requester offers words with a valid/ready handshake. The arbiter grants one requester at a time for a bounded burst, drives `fifo_wr_en`/`fifo_wr_data`, and never writes while `fifo_full` is high. It also latches any `fifo_wr_err` reported by the FIFO as a sticky status flag.

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-side arbiter.
// State encoding and default burst length.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int BURST_LEN_DEF = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request above
// last, wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_gnt;
  logic          w_found;
  int            w_j;

  // scan N slots starting one past the last grant
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    w_j     = 0;
    for (int k = 1; k <= N; k++) begin
      w_j   = (int'(last) + k) % N;
      w_idx = IW'(w_j);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign gnt_idx = w_gnt;
  assign any     = w_found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO
// write port, with a sticky write-error flag.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  N         = 4,
  parameter int  DW        = 32,
  parameter int  BURST_LEN = BURST_LEN_DEF,
  localparam int IW        = $clog2(N)
) (
  input  logic          wclk,
  input  logic          rst,
  input  logic [N-1:0]  req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]  req_ready,
  input  logic          fifo_full,
  input  logic          fifo_wr_err,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_wr_data,
  output logic [IW-1:0] grant_id,
  output logic          busy,
  output logic          err_sticky,
  input  logic          err_clr
);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_last;
  logic [7:0]    r_burst_cnt;
  logic          r_err;

  logic [IW-1:0] w_pick;
  logic          w_any;
  logic          w_sel_valid;
  logic          w_xfer;
  logic          w_last_beat;
  logic          w_release;
  logic          w_done;
  logic          w_in_grant;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req     (req_valid),
    .last    (r_last),
    .gnt_idx (w_pick),
    .any     (w_any)
  );

  // select the granted requester's valid and data
  always_comb begin
    w_sel_valid  = 1'b0;
    fifo_wr_data = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant == IW'(i)) begin
        w_sel_valid  = req_valid[i];
        fifo_wr_data = req_data[i*DW +: DW];
      end
    end
  end

  // reset gates the strobe so an aborted burst
  // leaves its pending word with the requester
  assign w_in_grant  = (r_state == ST_GRANT) & ~rst;
  assign w_xfer      = w_in_grant & w_sel_valid
                     & ~fifo_full;
  assign w_last_beat = w_xfer
                     & (r_burst_cnt == 8'(BURST_LEN-1));
  assign w_release   = ~w_sel_valid & ~fifo_full;
  assign w_done      = w_last_beat | w_release;

  // state register
  always_ff @(posedge wclk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any)  w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // outputs: strobe and ready are live from fifo_full
  always_comb begin
    busy       = (r_state == ST_GRANT);
    fifo_wr_en = w_xfer;
    req_ready  = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = w_in_grant & ~fifo_full
                   & (r_grant == IW'(i));
    end
  end

  // grant, round-robin pointer and burst counter
  always_ff @(posedge wclk) begin
    if (rst) begin
      r_grant     <= '0;
      r_last      <= IW'(N-1);
      r_burst_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_any) begin
        r_grant     <= w_pick;
        r_burst_cnt <= '0;
      end
    end else begin
      if (w_xfer) r_burst_cnt <= r_burst_cnt + 8'd1;
      if (w_done) r_last      <= r_grant;
    end
  end

  // sticky error: a new error beats a clear
  always_ff @(posedge wclk) begin
    if (rst)              r_err <= 1'b0;
    else if (fifo_wr_err) r_err <= 1'b1;
    else if (err_clr)     r_err <= 1'b0;
  end

  assign grant_id   = r_grant;
  assign err_sticky = r_err;

endmodule
